// File: rtl/accel_img_stream_ctrl_if.sv
// ============================================================================
// Module      : accel_img_stream_ctrl_if
// Description : Register-write, command and AXI-Stream bundle for
//               accel_img_stream_ctrl. The slave modport is the engine side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface accel_img_stream_ctrl_if #(
  parameter int IMG_WORDS = 32,
  parameter int TDATA_W   = 128
);
  localparam int AW = $clog2(IMG_WORDS);

  // Fill-buffer write port and commands
  logic                 i_wr_en;
  logic [AW-1:0]        i_wr_addr;
  logic [31:0]          i_wr_data;
  logic [3:0]           i_wr_strb;
  logic                 i_cmd_start;
  logic                 i_cmd_abort;
  // Stream
  logic                 i_tready;
  logic [TDATA_W-1:0]   o_tdata;
  logic                 o_tvalid;
  logic                 o_tlast;
  logic [TDATA_W/8-1:0] o_tkeep;
  // Status
  logic                 o_image_done_pulse;
  logic                 o_busy;
  logic                 o_buf_full;
  logic [1:0]           o_err_sticky;
  logic [15:0]          o_img_count;

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_wr_strb, i_cmd_start, i_cmd_abort, i_tready,
    output o_tdata, o_tvalid, o_tlast, o_tkeep, o_image_done_pulse, o_busy,
           o_buf_full, o_err_sticky, o_img_count
  );

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_wr_strb, i_cmd_start, i_cmd_abort, i_tready,
    input  o_tdata, o_tvalid, o_tlast, o_tkeep, o_image_done_pulse, o_busy,
           o_buf_full, o_err_sticky, o_img_count
  );
endinterface

`default_nettype wire

// File: rtl/accel_img_stream_ctrl.sv
// ============================================================================
// Module      : accel_img_stream_ctrl
// Description : Image buffer to AXI-Stream engine. Software fills a buffer
//               word by word, commits it with start, and the engine streams
//               committed images in order. One or two image buffers.
//               Optional macro ACC_IMG_CHECKSUM_EN adds o_checksum, the
//               mod-2^32 word sum of the last completed image.
//               Interface parameters must match IMG_WORDS / TDATA_W here.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_img_stream_ctrl #(
  parameter int IMG_WORDS = 32,
  parameter int TDATA_W   = 128,
  parameter int NUM_BUF   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  accel_img_stream_ctrl_if.slave bus
`ifdef ACC_IMG_CHECKSUM_EN
  ,
  output logic [31:0]            o_checksum
`endif
);
  localparam int            AW        = $clog2(IMG_WORDS);
  localparam int            WPB       = TDATA_W / 32;
  localparam int            BEATS     = IMG_WORDS * 32 / TDATA_W;
  localparam int            BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam bit            DUAL      = (NUM_BUF == 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state_q;
  logic                 wr_buf_q;      // buffer software is filling
  logic                 rd_buf_q;      // buffer streaming / next to stream
  logic [1:0]           busy_q;        // per buffer: committed or streaming
  logic [BW-1:0]        beat_q;
  logic                 abort_pend_q;
  logic [TDATA_W-1:0]   tdata_q;
  logic                 tvalid_q;
  logic                 tlast_q;
  logic                 done_q;
  logic [15:0]          count_q;
  logic [1:0]           err_q;
  // Slot 1 is never written or read when only one buffer is configured
  logic [31:0]          mem_q [2][IMG_WORDS];

  logic                 w_hs;
  logic                 w_rd_free;
  logic                 w_wr_locked;
  logic                 w_abort_now;
  logic                 w_start_req;
  logic                 w_start_ok;
  logic                 w_flush;
  logic [1:0]           busy_d;
  logic                 rd_buf_d;
  logic                 w_queue_nxt;
  logic [BW-1:0]        w_rd_beat;
  logic [TDATA_W-1:0]   w_beat_data;

  // Queue bookkeeping: a buffer freed in DONE is already free for a same-cycle start
  always_comb begin
    w_hs        = tvalid_q & bus.i_tready;
    w_rd_free   = (state_q == S_DONE) && (rd_buf_q == wr_buf_q);
    w_wr_locked = busy_q[wr_buf_q] && !w_rd_free;
    w_abort_now = bus.i_cmd_abort | abort_pend_q;
    w_start_req = bus.i_cmd_start && !w_abort_now;
    w_start_ok  = w_start_req && (!busy_q[wr_buf_q] || w_rd_free);
    busy_d      = busy_q;
    if (state_q == S_DONE) busy_d[rd_buf_q] = 1'b0;
    if (w_start_ok)        busy_d[wr_buf_q] = 1'b1;
    rd_buf_d    = (state_q == S_DONE && DUAL) ? ~rd_buf_q : rd_buf_q;
    w_queue_nxt = busy_d[rd_buf_d];
    // Abort outside STREAM is immediate; inside STREAM it waits for the held beat
    w_flush     = (bus.i_cmd_abort && state_q != S_STREAM) ||
                  (state_q == S_STREAM && w_abort_now && w_hs);
  end

  // Gather the next beat to present: beat 0 in LOAD, otherwise the one after beat_q
  always_comb begin
    w_beat_data = '0;
    w_rd_beat   = (state_q == S_LOAD) ? '0 : beat_q + 1'b1;
    for (int j = 0; j < WPB; j++) begin
      w_beat_data[j*32 +: 32] = mem_q[rd_buf_q][AW'(int'(w_rd_beat) * WPB + j)];
    end
  end

  // Byte-merged word writes into the fill buffer; locked buffers are left alone
  always_ff @(posedge i_clk) begin
    if (bus.i_wr_en && !w_wr_locked) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.i_wr_strb[b]) mem_q[wr_buf_q][bus.i_wr_addr][b*8 +: 8] <= bus.i_wr_data[b*8 +: 8];
      end
    end
  end

`ifdef ACC_IMG_CHECKSUM_EN
  logic [31:0] sum_q;
  logic [31:0] csum_q;
  logic [31:0] w_beat_sum;

  // Word sum of the beat currently presented on the stream
  always_comb begin
    w_beat_sum = '0;
    for (int j = 0; j < WPB; j++) w_beat_sum = w_beat_sum + tdata_q[j*32 +: 32];
  end

  assign o_checksum = csum_q;
`endif

  // Control FSM, stream output registers, queue state and sticky status
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      wr_buf_q     <= 1'b0;
      rd_buf_q     <= 1'b0;
      busy_q       <= '0;
      beat_q       <= '0;
      abort_pend_q <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
      err_q        <= '0;
`ifdef ACC_IMG_CHECKSUM_EN
      sum_q        <= '0;
      csum_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (w_flush) begin
        state_q      <= S_IDLE;
        wr_buf_q     <= 1'b0;
        rd_buf_q     <= 1'b0;
        busy_q       <= '0;
        abort_pend_q <= 1'b0;
        tvalid_q     <= 1'b0;
        tlast_q      <= 1'b0;
        err_q        <= '0;
      end else if (state_q == S_STREAM && w_abort_now) begin
        // Hold the presented beat, marked as last, until the sink takes it
        abort_pend_q <= 1'b1;
        tlast_q      <= 1'b1;
      end else begin
        busy_q   <= busy_d;
        rd_buf_q <= rd_buf_d;
        if (w_start_ok && DUAL)                      wr_buf_q <= ~wr_buf_q;
        if (w_start_req && !w_start_ok)              err_q[0] <= 1'b1;
        if (!DUAL && bus.i_wr_en && w_wr_locked)     err_q[1] <= 1'b1;
        case (state_q)
          S_IDLE: begin
            if (w_queue_nxt) state_q <= S_LOAD;
          end
          S_LOAD: begin
            tdata_q  <= w_beat_data;
            tvalid_q <= 1'b1;
            tlast_q  <= (LAST_BEAT == '0);
            beat_q   <= '0;
`ifdef ACC_IMG_CHECKSUM_EN
            sum_q    <= '0;
`endif
            state_q  <= S_STREAM;
          end
          S_STREAM: begin
            if (w_hs) begin
`ifdef ACC_IMG_CHECKSUM_EN
              sum_q <= sum_q + w_beat_sum;
`endif
              if (beat_q == LAST_BEAT) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                done_q   <= 1'b1;
                count_q  <= count_q + 16'd1;
`ifdef ACC_IMG_CHECKSUM_EN
                csum_q   <= sum_q + w_beat_sum;
`endif
                state_q  <= S_DONE;
              end else begin
                beat_q  <= beat_q + 1'b1;
                tdata_q <= w_beat_data;
                tlast_q <= ((beat_q + 1'b1) == LAST_BEAT);
              end
            end
          end
          S_DONE: begin
            state_q <= w_queue_nxt ? S_LOAD : S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_tdata            = tdata_q;
  assign bus.o_tvalid           = tvalid_q;
  assign bus.o_tlast            = tlast_q;
  assign bus.o_tkeep            = {(TDATA_W/8){tvalid_q}};
  assign bus.o_image_done_pulse = done_q;
  assign bus.o_busy             = (state_q != S_IDLE) || (|busy_q);
  assign bus.o_buf_full         = DUAL ? (&busy_q) : busy_q[0];
  assign bus.o_err_sticky       = err_q;
  assign bus.o_img_count        = count_q;

endmodule

`default_nettype wire

// File: tb/tb_accel_img_stream_ctrl.sv
// ============================================================================
// Module      : tb_accel_img_stream_ctrl
// Description : Directed self-checking bench for accel_img_stream_ctrl.
//               u_dut0 uses the default configuration; u_dut1 is a single
//               buffer, 64-bit stream, 16-word image instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accel_img_stream_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  accel_img_stream_ctrl_if #(.IMG_WORDS(32), .TDATA_W(128)) bus0 ();
  accel_img_stream_ctrl_if #(.IMG_WORDS(16), .TDATA_W(64))  bus1 ();

`ifdef ACC_IMG_CHECKSUM_EN
  logic [31:0] csum0;
  logic [31:0] csum1;
`endif

  accel_img_stream_ctrl #(.IMG_WORDS(32), .TDATA_W(128), .NUM_BUF(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave)
`ifdef ACC_IMG_CHECKSUM_EN
    , .o_checksum(csum0)
`endif
  );

  accel_img_stream_ctrl #(.IMG_WORDS(16), .TDATA_W(64), .NUM_BUF(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave)
`ifdef ACC_IMG_CHECKSUM_EN
    , .o_checksum(csum1)
`endif
  );

  // Captured stream of u_dut0
  logic [127:0] bq[$];
  bit           lq[$];
  int           bc[$];
  int           dq[$];
  int           viol;
  int           keep_bad;
  bit           tmo;

  function automatic logic [127:0] exp_beat(input logic [31:0] base, input int k);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = base + 32'(4 * k + j);
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus0.i_wr_en = 0; bus0.i_cmd_start = 0; bus0.i_cmd_abort = 0; bus0.i_tready = 0;
    bus1.i_wr_en = 0; bus1.i_cmd_start = 0; bus1.i_cmd_abort = 0; bus1.i_tready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic fill0(input logic [31:0] base, input int step);
    for (int i = 0; i < 32; i++) begin
      bus0.i_wr_en = 1; bus0.i_wr_addr = 5'(i); bus0.i_wr_data = base + 32'(i * step);
      bus0.i_wr_strb = 4'hF;
      @(posedge clk); #1;
    end
    bus0.i_wr_en = 0;
  endtask

  task automatic start0();
    bus0.i_cmd_start = 1;
    @(posedge clk); #1;
    bus0.i_cmd_start = 0;
  endtask

  // Records handshakes, done pulses and stall-stability violations of u_dut0
  task automatic collect0(input int max_cyc, input bit toggle, input int n_done);
    bit           pv, pr, pl;
    logic [127:0] pd;
    int           dones;
    bq.delete(); lq.delete(); bc.delete(); dq.delete();
    viol = 0; keep_bad = 0; dones = 0; pv = 0; pr = 0; pl = 0; pd = '0;
    for (int cyc = 0; cyc < max_cyc && dones < n_done; cyc++) begin
      @(negedge clk);
      if (pv && !pr) begin
        if (bus0.o_tvalid !== 1'b1 || bus0.o_tdata !== pd || bus0.o_tlast !== pl) viol++;
      end
      if (bus0.o_tvalid === 1'b1 && bus0.i_tready === 1'b1) begin
        bq.push_back(bus0.o_tdata); lq.push_back(bus0.o_tlast); bc.push_back(cyc);
        if (bus0.o_tkeep !== 16'hFFFF) keep_bad++;
      end
      if (bus0.o_image_done_pulse === 1'b1) begin
        dq.push_back(cyc); dones++;
      end
      pv = bus0.o_tvalid; pr = bus0.i_tready; pd = bus0.o_tdata; pl = bus0.o_tlast;
      @(posedge clk); #1;
      if (toggle) bus0.i_tready = ~bus0.i_tready;
    end
    tmo = (dones < n_done);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (bus0.o_tvalid !== 0 || bus0.o_tlast !== 0 || bus0.o_tkeep !== '0 || bus0.o_tdata !== '0) begin
      n_fail++; $display("FAIL reset_stream: tvalid=%b tlast=%b tkeep=%h tdata=%h required all 0",
                         bus0.o_tvalid, bus0.o_tlast, bus0.o_tkeep, bus0.o_tdata);
    end
    n_checks++;
    if (bus0.o_image_done_pulse !== 0 || bus0.o_busy !== 0 || bus0.o_buf_full !== 0 ||
        bus0.o_err_sticky !== 2'b00 || bus0.o_img_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_status: done=%b busy=%b full=%b err=%b cnt=%0d required all 0",
                         bus0.o_image_done_pulse, bus0.o_busy, bus0.o_buf_full, bus0.o_err_sticky, bus0.o_img_count);
    end
    n_checks++;
    if (bus1.o_tvalid !== 0 || bus1.o_busy !== 0 || bus1.o_err_sticky !== 2'b00) begin
      n_fail++; $display("FAIL reset_dut1: tvalid=%b busy=%b err=%b required 0", bus1.o_tvalid, bus1.o_busy, bus1.o_err_sticky);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    fill0(32'h1000, 1);
    bus0.i_tready = 1;
    start0();
    collect0(40, 1'b0, 1);
    n_checks++;
    if (tmo !== 0 || bq.size() !== 8) begin
      n_fail++; $display("FAIL basic_beats: got %0d beats timeout=%b, required 8 beats", bq.size(), tmo);
    end
    for (int k = 0; k < bq.size() && k < 8; k++) begin
      n_checks++;
      if (bq[k] !== exp_beat(32'h1000, k) || lq[k] !== (k == 7)) begin
        n_fail++; $display("FAIL basic_beat%0d: data=%h last=%b required data=%h last=%b",
                           k, bq[k], lq[k], exp_beat(32'h1000, k), (k == 7));
      end
    end
    n_checks++;
    if (bc.size() > 0 && bc[0] !== 1) begin
      n_fail++; $display("FAIL basic_latency: first beat at cycle %0d after start, required 1 (tvalid at t+2)", bc[0]);
    end
    n_checks++;
    if (bc.size() == 8 && dq.size() == 1 && dq[0] !== bc[7] + 1) begin
      n_fail++; $display("FAIL basic_done_timing: done at %0d required %0d", dq[0], bc[7] + 1);
    end
    n_checks++;
    if (keep_bad !== 0 || bus0.o_img_count !== 16'd1 || bus0.o_busy !== 0) begin
      n_fail++; $display("FAIL basic_status: keep_bad=%0d cnt=%0d busy=%b required 0/1/0",
                         keep_bad, bus0.o_img_count, bus0.o_busy);
    end
  endtask

  task automatic test_backpressure();
    fill0(32'h1000, 1);
    bus0.i_tready = 0;
    start0();
    collect0(60, 1'b1, 1);
    n_checks++;
    if (tmo !== 0 || bq.size() !== 8 || viol !== 0) begin
      n_fail++; $display("FAIL bp_handshakes: beats=%0d viol=%0d timeout=%b required 8/0/0", bq.size(), viol, tmo);
    end
    for (int k = 0; k < bq.size() && k < 8; k++) begin
      n_checks++;
      if (bq[k] !== exp_beat(32'h1000, k) || lq[k] !== (k == 7)) begin
        n_fail++; $display("FAIL bp_beat%0d: data=%h last=%b required data=%h last=%b",
                           k, bq[k], lq[k], exp_beat(32'h1000, k), (k == 7));
      end
    end
    n_checks++;
    if (bus0.o_img_count !== 16'd2) begin
      n_fail++; $display("FAIL bp_count: cnt=%0d required 2", bus0.o_img_count);
    end
    bus0.i_tready = 0;
  endtask

  task automatic test_double_buffer();
    do_reset();
    fill0(32'h2000, 1);
    bus0.i_tready = 0;
    start0();                     // A
    fill0(32'h3000, 1);           // B fills while A holds beat 0
    start0();                     // B queued
    @(negedge clk);
    n_checks++;
    if (bus0.o_buf_full !== 1'b1 || bus0.o_err_sticky !== 2'b00) begin
      n_fail++; $display("FAIL db_full: full=%b err=%b required 1/00", bus0.o_buf_full, bus0.o_err_sticky);
    end
    @(posedge clk); #1;
    start0();                     // C rejected
    @(negedge clk);
    n_checks++;
    if (bus0.o_err_sticky !== 2'b01) begin
      n_fail++; $display("FAIL db_err0: err=%b required 01", bus0.o_err_sticky);
    end
    @(posedge clk); #1;
    bus0.i_tready = 1;
    collect0(80, 1'b0, 2);
    n_checks++;
    if (tmo !== 0 || bq.size() !== 16 || dq.size() !== 2) begin
      n_fail++; $display("FAIL db_beats: beats=%0d dones=%0d timeout=%b required 16/2/0", bq.size(), dq.size(), tmo);
    end
    for (int k = 0; k < bq.size() && k < 16; k++) begin
      n_checks++;
      if (bq[k] !== exp_beat((k < 8) ? 32'h2000 : 32'h3000, k % 8)) begin
        n_fail++; $display("FAIL db_beat%0d: data=%h required %h", k, bq[k], exp_beat((k < 8) ? 32'h2000 : 32'h3000, k % 8));
      end
    end
    n_checks++;
    if (bc.size() == 16 && bc[8] - bc[7] !== 3) begin
      n_fail++; $display("FAIL db_gap: beat spacing %0d required 3", bc[8] - bc[7]);
    end
    n_checks++;
    if (bus0.o_img_count !== 16'd2 || bus0.o_busy !== 0) begin
      n_fail++; $display("FAIL db_count: cnt=%0d busy=%b required 2/0", bus0.o_img_count, bus0.o_busy);
    end
    bus0.i_tready = 0;
  endtask

  task automatic test_abort();
    int seen_v, seen_d;
    do_reset();
    fill0(32'h4000, 1);
    bus0.i_tready = 0;
    start0(); start0(); start0();   // A, B queued, C rejected
    @(negedge clk);
    n_checks++;
    if (bus0.o_err_sticky !== 2'b01 || bus0.o_buf_full !== 1'b1 || bus0.o_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL abort_setup: err=%b full=%b tvalid=%b required 01/1/1",
                         bus0.o_err_sticky, bus0.o_buf_full, bus0.o_tvalid);
    end
    @(posedge clk); #1;
    bus0.i_tready = 1;
    repeat (3) @(posedge clk);
    #1;
    bus0.i_tready = 0; bus0.i_cmd_abort = 1;
    @(posedge clk); #1;
    bus0.i_cmd_abort = 0;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      n_checks++;
      if (bus0.o_tvalid !== 1'b1 || bus0.o_tlast !== 1'b1 || bus0.o_tdata !== exp_beat(32'h4000, 3)) begin
        n_fail++; $display("FAIL abort_hold%0d: tvalid=%b tlast=%b data=%h required 1/1/%h",
                           r, bus0.o_tvalid, bus0.o_tlast, bus0.o_tdata, exp_beat(32'h4000, 3));
      end
      @(posedge clk); #1;
    end
    bus0.i_tready = 1;
    @(posedge clk); #1;
    bus0.i_tready = 0;
    seen_v = 0; seen_d = 0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      if (bus0.o_tvalid === 1'b1) seen_v++;
      if (bus0.o_image_done_pulse === 1'b1) seen_d++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen_v !== 0 || seen_d !== 0) begin
      n_fail++; $display("FAIL abort_quiet: valid cycles=%0d done pulses=%0d required 0/0", seen_v, seen_d);
    end
    n_checks++;
    if (bus0.o_busy !== 0 || bus0.o_err_sticky !== 2'b00 || bus0.o_img_count !== 16'd0 || bus0.o_buf_full !== 0) begin
      n_fail++; $display("FAIL abort_status: busy=%b err=%b cnt=%0d full=%b required 0/00/0/0",
                         bus0.o_busy, bus0.o_err_sticky, bus0.o_img_count, bus0.o_buf_full);
    end
    // Abort while in LOAD: nothing is ever presented
    bus0.i_tready = 1;
    start0();
    bus0.i_cmd_abort = 1;
    @(posedge clk); #1;
    bus0.i_cmd_abort = 0;
    seen_v = 0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      if (bus0.o_tvalid === 1'b1) seen_v++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen_v !== 0 || bus0.o_busy !== 0) begin
      n_fail++; $display("FAIL abort_load: valid cycles=%0d busy=%b required 0/0", seen_v, bus0.o_busy);
    end
    bus0.i_tready = 0;
  endtask

  task automatic test_single_buf();
    logic [63:0] got[8];
    logic [63:0] exp;
    int nb, nd;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus1.i_wr_en = 1; bus1.i_wr_addr = 4'(i); bus1.i_wr_data = 32'h5000 + 32'(i); bus1.i_wr_strb = 4'hF;
      @(posedge clk); #1;
    end
    bus1.i_wr_addr = 4'd0; bus1.i_wr_data = 32'hAAAAAAAA; bus1.i_wr_strb = 4'b0010;
    @(posedge clk); #1;
    bus1.i_wr_en = 0;
    bus1.i_tready = 0;
    bus1.i_cmd_start = 1;
    @(posedge clk); #1;
    bus1.i_cmd_start = 0;
    @(posedge clk); #1;
    bus1.i_wr_en = 1; bus1.i_wr_addr = 4'd3; bus1.i_wr_data = 32'hDEADBEEF; bus1.i_wr_strb = 4'hF;
    @(posedge clk); #1;
    bus1.i_wr_en = 0;
    @(negedge clk);
    n_checks++;
    if (bus1.o_err_sticky !== 2'b10 || bus1.o_buf_full !== 1'b1) begin
      n_fail++; $display("FAIL sb_locked: err=%b full=%b required 10/1", bus1.o_err_sticky, bus1.o_buf_full);
    end
    @(posedge clk); #1;
    bus1.i_tready = 1;
    nb = 0; nd = 0;
    for (int c = 0; c < 40 && nd == 0; c++) begin
      @(negedge clk);
      if (bus1.o_tvalid === 1'b1 && nb < 8) begin got[nb] = bus1.o_tdata; nb++; end
      if (bus1.o_image_done_pulse === 1'b1) nd++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (nb !== 8 || nd !== 1 || bus1.o_img_count !== 16'd1) begin
      n_fail++; $display("FAIL sb_beats: beats=%0d dones=%0d cnt=%0d required 8/1/1", nb, nd, bus1.o_img_count);
    end
    for (int k = 0; k < nb; k++) begin
      exp = {32'h5000 + 32'(2 * k + 1), (k == 0) ? 32'h0000AA00 : 32'h5000 + 32'(2 * k)};
      n_checks++;
      if (got[k] !== exp) begin
        n_fail++; $display("FAIL sb_beat%0d: data=%h required %h", k, got[k], exp);
      end
    end
    bus1.i_tready = 0;
  endtask

  task automatic test_async_reset();
    int seen_v, seen_d;
    do_reset();
    fill0(32'h6000, 1);
    bus0.i_tready = 1;
    start0();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus0.o_tvalid !== 0 || bus0.o_busy !== 0 || bus0.o_img_count !== 16'd0) begin
      n_fail++; $display("FAIL async_reset: tvalid=%b busy=%b cnt=%0d required 0/0/0",
                         bus0.o_tvalid, bus0.o_busy, bus0.o_img_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_v = 0; seen_d = 0;
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      if (bus0.o_tvalid === 1'b1) seen_v++;
      if (bus0.o_image_done_pulse === 1'b1) seen_d++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen_v !== 0 || seen_d !== 0) begin
      n_fail++; $display("FAIL async_quiet: valid cycles=%0d done pulses=%0d required 0/0", seen_v, seen_d);
    end
    bus0.i_tready = 0;
  endtask

`ifdef ACC_IMG_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (csum0 !== 32'd0) begin
      n_fail++; $display("FAIL csum_reset: checksum=%h required 0", csum0);
    end
    @(posedge clk); #1;
    fill0(32'hFFFFFFFF, 0);
    bus0.i_tready = 1;
    start0();
    collect0(40, 1'b0, 1);
    n_checks++;
    if (tmo !== 0 || csum0 !== 32'hFFFFFFE0) begin
      n_fail++; $display("FAIL csum_value: checksum=%h timeout=%b required FFFFFFE0", csum0, tmo);
    end
    bus0.i_tready = 0;
  endtask
`endif

  initial begin
    bus0.i_wr_en = 0; bus0.i_wr_addr = '0; bus0.i_wr_data = '0; bus0.i_wr_strb = '0;
    bus0.i_cmd_start = 0; bus0.i_cmd_abort = 0; bus0.i_tready = 0;
    bus1.i_wr_en = 0; bus1.i_wr_addr = '0; bus1.i_wr_data = '0; bus1.i_wr_strb = '0;
    bus1.i_cmd_start = 0; bus1.i_cmd_abort = 0; bus1.i_tready = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_double_buffer();
    test_abort();
    test_single_buf();
    test_async_reset();
`ifdef ACC_IMG_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire

// File: doc/accel_img_stream_ctrl.md
Name: accel_img_stream_ctrl

Overview:
Parametrised image-buffer-to-AXI-Stream engine for the accelerator subsystem. It generalises the fixed 32x32-bit / 128-bit image path to configurable image size and stream width, with optional double buffering. Software writes words into a fill buffer over the register-write interface, then issues start. The block streams the committed image to class_top while the next image is being filled.

Parameters:
IMG_WORDS, 32, 32-bit words per image; power of 2, >= TDATA_W/32
TDATA_W, 128, stream width; multiple of 32; IMG_WORDS*32 divisible by TDATA_W
NUM_BUF, 2, image buffers; 1 or 2 only
AW, $clog2(IMG_WORDS), word address width (derived, not overridable)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; asynchronous assert, active-low
i_wr_en  in  1  single-cycle word write strobe into fill buffer
i_wr_addr  in  AW  word index
i_wr_data  in  32  write data
i_wr_strb  in  4  byte enables
i_cmd_start  in  1  pulse: commit fill buffer to stream queue
i_cmd_abort  in  1  pulse: terminate stream, flush queue
i_tready  in  1  sink ready
o_tdata  out  TDATA_W  stream data
o_tvalid  out  1  stream valid
o_tlast  out  1  last beat of image
o_tkeep  out  TDATA_W/8  all ones while o_tvalid, else 0
o_image_done_pulse  out  1  1-cycle pulse per fully streamed image
o_busy  out  1  streaming or queue non-empty
o_buf_full  out  1  no free fill buffer
o_err_sticky  out  2  [0] start-while-full, [1] write-while-locked; cleared by reset or abort
o_img_count  out  16  completed images, wraps 0xFFFF->0

Behaviour:
- Reset: all outputs 0, buffer contents undefined, wr_buf=0, queue empty.
- BEATS = IMG_WORDS*32/TDATA_W. WPB = TDATA_W/32. Beat k carries words k*WPB..k*WPB+WPB-1, lowest index in the LSBs.
- Writes: byte-merged into the fill buffer, taking effect the next cycle.
  - NUM_BUF=1: while the buffer is committed or streaming, writes are dropped and err[1] is set.
  - NUM_BUF=2: writes never touch the streaming buffer.
- Start:
  - If a free buffer exists, the fill buffer joins the queue and wr_buf toggles (NUM_BUF=2).
  - Otherwise start is ignored and err[0] is set.
  - o_buf_full = all buffers committed or streaming.
- FSM states:
  - IDLE: queue non-empty -> LOAD.
  - LOAD: 1 cycle; register beat 0; o_tvalid=1 next cycle -> STREAM.
  - STREAM: on o_tvalid&&i_tready, advance beat; after the handshake of beat BEATS-1 -> DONE.
  - DONE: 1 cycle; o_image_done_pulse=1, o_img_count++, buffer freed. Go to LOAD if queue non-empty, else IDLE.
- Latency: start at cycle t -> o_tvalid at t+2 from IDLE. Back-to-back images have a 2-cycle bubble (DONE, LOAD).
- AXI-S rules:
  - o_tdata, o_tlast and o_tkeep are held stable while o_tvalid && !i_tready.
  - o_tvalid never drops without a handshake, except on abort (below).
  - o_tlast=1 only on beat BEATS-1.
- Start and write in the same cycle: the write lands in the buffer being committed (write before commit).
- Start in the same cycle as DONE frees a buffer: the freed buffer counts as free, so start succeeds.
- Abort:
  - The currently presented beat is held until handshake, with o_tlast forced to 1.
  - Then go to IDLE, queue flushed, all buffers free, wr_buf=0, err cleared.
  - No done pulse or count increment for the aborted image.
  - Abort in IDLE or LOAD takes effect immediately with no beat emitted.
  - Abort has priority over a same-cycle start.
- Asynchronous reset mid-stream: o_tvalid drops immediately; no completion is signalled.

Optional Feature:
ACC_IMG_CHECKSUM_EN
- Defined: adds output o_checksum[31:0], the mod-2^32 sum of all IMG_WORDS words of the last completed image.
  - Accumulated per handshaken beat.
  - Updated in the same cycle as o_image_done_pulse; reset 0; unchanged on abort.
- Undefined: port absent, no adder logic.

Test Plan:
1. Defaults: write words 0..31 = 0x1000+i, start, i_tready=1 -> 8 beats, beat0=0x00001003_00001002_00001001_00001000, o_tlast on beat 7, o_image_done_pulse 1 cycle after beat 7, o_img_count=1.
2. Backpressure: toggle i_tready 1/0 every cycle -> o_tdata/o_tlast stable during stalls, exactly 8 handshakes, identical data to test 1.
3. Double buffer: start image A, fill B while A streams, start B, start C while both busy -> A then B streamed with a 2-cycle gap, C rejected, err[0]=1, o_img_count=2.
4. Abort: i_tready=0 during beat 3, pulse abort -> beat 3 held with o_tlast=1; after handshake o_tvalid=0, no done pulse, o_busy=0, err=0.
5. NUM_BUF=1, TDATA_W=64, IMG_WORDS=16: write during stream -> err[1]=1, streamed data unchanged, 8 beats.
6. ACC_IMG_CHECKSUM_EN: all words 0xFFFFFFFF, 32 words -> o_checksum=0xFFFFFFE0 at done pulse.
